// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one user command becomes one
// read or write burst, finished by a one-cycle done pulse carrying the response.
module axi4_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic                    awvalid_q;
  logic                    arvalid_q;
  logic [1:0]              done_resp_q;
  logic                    in_wdata;
  logic                    in_rdata;
  logic                    last_beat;

  assign in_wdata  = (state_q == S_WDATA);
  assign in_rdata  = (state_q == S_RDATA);
  assign last_beat = (beat_q == len_q);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      beat_q      <= 8'd0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      done_resp_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr & WORD_MASK;
            len_q  <= cmd_len;
            beat_q <= 8'd0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              state_q   <= S_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            state_q   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (wr_valid && WREADY) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (BVALID) begin
            done_resp_q <= BRESP;
            state_q     <= S_DONE;
          end
        end
        S_RADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (RVALID && rd_ready) begin
            beat_q <= beat_q + 8'd1;
            // Early RLAST or a missing RLAST both end the burst as a length mismatch.
            if (RLAST || last_beat) begin
              done_resp_q <= (RLAST && last_beat) ? 2'b00 : 2'b10;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign done_resp = done_resp_q;

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;

  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;

  // Data-phase signals are straight pass-throughs, gated to zero outside their state.
  assign WVALID   = in_wdata & wr_valid;
  assign WDATA    = in_wdata ? wr_data : '0;
  assign WLAST    = in_wdata & last_beat;
  assign wr_ready = in_wdata & WREADY;
  assign BREADY   = (state_q == S_WRESP);

  assign RREADY   = in_rdata & rd_ready;
  assign rd_valid = in_rdata & RVALID;
  assign rd_data  = in_rdata ? RDATA : '0;
  assign rd_last  = in_rdata & RLAST;

endmodule
